fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: address of the first fetched instruction.
REQ-002 Parameter NOP, default 16'h0000: instruction word presented to Decode during bubbles.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 imem_req  out  1  fetch request; held until the memory grants it.
REQ-006 imem_addr  out  32  halfword-aligned fetch address; stable while imem_req=1.
REQ-007 imem_gnt  in  1  memory accepts the request this cycle.
REQ-008 imem_rvalid  in  1  read data valid; arrives exactly one cycle after imem_gnt.
REQ-009 imem_rdata  in  16  fetched instruction word.
REQ-010 stall  in  1  Execute global_disable; freezes the front end.
REQ-011 branch_taken  in  1  Execute resolved a taken branch this cycle.
REQ-012 delta_instruction  in  32  signed branch offset, in instructions, relative to the branch's own address.
REQ-013 instruction  out  16  registered instruction to Decode.
REQ-014 pc  out  32  address of the word currently on instruction.

Function
REQ-015 FSM states: FETCH (request pending), WAIT (granted, data due), DROP (stale data due), HOLD (data buffered under stall).
REQ-016 FETCH: imem_req=1, imem_addr=fetch_pc; on imem_gnt go to WAIT and set fetch_pc=fetch_pc+2.
REQ-017 WAIT with imem_rvalid and stall=0: instruction<=imem_rdata, pc<=that word's address, go to FETCH; request re-asserted in the same cycle (one instruction per two cycles, zero-wait memory).
REQ-018 WAIT with imem_rvalid and stall=1: capture imem_rdata into a 1-entry skid buffer, go to HOLD; instruction and pc unchanged.
REQ-019 HOLD: imem_req=0; when stall falls, buffer moves to instruction/pc, go to FETCH.
REQ-020 stall=1 in FETCH: imem_req deasserted, instruction, pc and fetch_pc held.
REQ-021 The block tracks dec_pc and exe_pc (address of the word in Decode and in Execute); these advance only when instruction advances; exe_pc<=dec_pc, dec_pc<=pc.
REQ-022 branch_taken: target = exe_pc + (delta_instruction << 1), modulo 2^32; fetch_pc<=target; instruction<=NOP; skid buffer cleared.
REQ-023 Branch in WAIT, or in the grant cycle of FETCH: go to DROP; the following imem_rvalid is discarded; then FETCH at target.
REQ-024 Branch in FETCH without grant, or in HOLD: go directly to FETCH at target; an ungranted request is withdrawn.
REQ-025 branch_taken has priority over stall in the same cycle; stall then applies from the next cycle.
REQ-026 A NOP bubble carries pc=target-2, which Execute ignores; NOP never triggers a branch.
REQ-027 imem_addr[0] is always 0; fetch_pc wraps from 32'hFFFF_FFFE to 0.

Reset
REQ-028 rst_n low asynchronously forces state=FETCH, fetch_pc=RESET_PC, pc=RESET_PC-2, dec_pc=exe_pc=RESET_PC-2, instruction=NOP, imem_req=0, skid buffer empty.
REQ-029 imem_req rises on the first rising clk edge after rst_n deasserts.
REQ-030 Reset during WAIT discards the in-flight response; any imem_rvalid in the first cycle after release is ignored.

Structure
REQ-031 Shared cpu package holds the FSM state enum, the NOP constant and the instruction/address width constants used by Decode and Execute.
REQ-032 One sub-module is natural: fetch_skid (1-entry data+address buffer with valid and flush inputs).

Verification
REQ-033 Reset release, zero-wait memory returning 16'h2005 at 0 -> imem_req in cycle 1, instruction=16'h2005 with pc=0 two cycles later, next imem_addr=2.
REQ-034 stall high during WAIT for 3 cycles, rdata 16'h1FC2 -> instruction unchanged for 3 cycles, 16'h1FC2 appears the cycle after stall falls, no re-fetch of that address.
REQ-035 branch_taken with exe_pc=32'h10, delta=-4, during WAIT -> next rvalid dropped, instruction=NOP, next imem_addr=32'h08.
REQ-036 branch_taken and stall together in HOLD, delta=+3, exe_pc=0 -> buffer flushed, imem_addr=32'h06 once stall drops.
REQ-037 rst_n pulsed low mid-WAIT -> outputs return to reset values immediately, stale rvalid ignored, fetch restarts at RESET_PC.
REQ-038 Fetch at 32'hFFFF_FFFE -> next imem_addr=32'h0000_0000.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared front-end definitions: fetch FSM states, NOP encoding, datapath widths
// and the branch-target helper used by Fetch and Execute.
package fetch_ctrl_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_WORD = 16'h0000;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_WAIT,
        ST_DROP,
        ST_HOLD
    } fetch_state_t;

    // Offsets count instructions, so scale to halfwords; bit 0 forced low to keep alignment.
    function automatic logic [ADDR_W-1:0] branch_target(
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] delta
    );
        logic [ADDR_W-1:0] t;
        t = base + (delta << 1);
        return {t[ADDR_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory bus plus the Execute/Decode side signals of the fetch unit.
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic                 imem_req;
    logic [ADDR_W-1:0]    imem_addr;
    logic                 imem_gnt;
    logic                 imem_rvalid;
    logic [INSTR_W-1:0]   imem_rdata;
    logic                 stall;
    logic                 branch_taken;
    logic [ADDR_W-1:0]    delta_instruction;
    logic [INSTR_W-1:0]   instruction;
    logic [ADDR_W-1:0]    pc;

    modport master (
        output imem_req, imem_addr, instruction, pc,
        input  imem_gnt, imem_rvalid, imem_rdata, stall, branch_taken, delta_instruction
    );

    modport slave (
        input  imem_req, imem_addr, instruction, pc,
        output imem_gnt, imem_rvalid, imem_rdata, stall, branch_taken, delta_instruction
    );

endinterface

// File: rtl/fetch_skid.sv
// One-entry buffer parking a fetched word and its address while the pipe is stalled.
module fetch_skid
    import fetch_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               pop,
    input  logic               flush,
    input  logic [INSTR_W-1:0] load_data,
    input  logic [ADDR_W-1:0]  load_addr,
    output logic               valid,
    output logic [INSTR_W-1:0] data,
    output logic [ADDR_W-1:0]  addr
);

    // Flush wins so a redirect can never let a wrong-path word escape.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            addr  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            addr  <= load_addr;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch stage: issues halfword fetches, absorbs stalls with a skid buffer and
// redirects on taken branches, discarding any response already in flight.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] NOP      = NOP_WORD
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_ctrl_if.master bus
);

    fetch_state_t       state;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  dec_pc;
    logic [ADDR_W-1:0]  exe_pc;
    logic [ADDR_W-1:0]  target;
    logic [ADDR_W-1:0]  word_addr;
    logic               granted;
    logic               skid_load;
    logic               skid_pop;
    logic               skid_valid;
    logic [INSTR_W-1:0] skid_data;
    logic [ADDR_W-1:0]  skid_addr;
    logic               keep_dropping;

    assign target    = branch_target(exe_pc, bus.delta_instruction);
    assign granted   = bus.imem_req & bus.imem_gnt;
    assign word_addr = fetch_pc - 32'd2;
    assign bus.imem_addr = fetch_pc;

    assign skid_load = (state == ST_WAIT) & bus.imem_rvalid & bus.stall & ~bus.branch_taken;
    assign skid_pop  = (state == ST_HOLD) & ~bus.stall & ~bus.branch_taken;

    // A response is still owed after a redirect if the grant happens now or data has not yet returned.
    assign keep_dropping = ((state == ST_FETCH) & granted) |
                           (((state == ST_WAIT) | (state == ST_DROP)) & ~bus.imem_rvalid);

    fetch_skid u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (skid_load),
        .pop       (skid_pop),
        .flush     (bus.branch_taken),
        .load_data (bus.imem_rdata),
        .load_addr (word_addr),
        .valid     (skid_valid),
        .data      (skid_data),
        .addr      (skid_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_FETCH;
            fetch_pc        <= RESET_PC;
            bus.pc          <= RESET_PC - 32'd2;
            dec_pc          <= RESET_PC - 32'd2;
            exe_pc          <= RESET_PC - 32'd2;
            bus.instruction <= NOP;
            bus.imem_req    <= 1'b0;
        end else if (bus.branch_taken) begin
            fetch_pc        <= target;
            bus.instruction <= NOP;
            bus.pc          <= target - 32'd2;
            dec_pc          <= bus.pc;
            exe_pc          <= dec_pc;
            if (keep_dropping) begin
                state        <= ST_DROP;
                bus.imem_req <= 1'b0;
            end else begin
                state        <= ST_FETCH;
                bus.imem_req <= 1'b1;
            end
        end else begin
            case (state)
                ST_FETCH: begin
                    if (granted) begin
                        state        <= ST_WAIT;
                        fetch_pc     <= fetch_pc + 32'd2;
                        bus.imem_req <= 1'b0;
                    end else begin
                        bus.imem_req <= ~bus.stall;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_rvalid) begin
                        if (bus.stall) begin
                            state <= ST_HOLD;
                        end else begin
                            bus.instruction <= bus.imem_rdata;
                            bus.pc          <= word_addr;
                            dec_pc          <= bus.pc;
                            exe_pc          <= dec_pc;
                            state           <= ST_FETCH;
                            bus.imem_req    <= 1'b1;
                        end
                    end
                end
                ST_DROP: begin
                    if (bus.imem_rvalid) begin
                        state        <= ST_FETCH;
                        bus.imem_req <= ~bus.stall;
                    end
                end
                ST_HOLD: begin
                    if (!bus.stall) begin
                        if (skid_valid) begin
                            bus.instruction <= skid_data;
                            bus.pc          <= skid_addr;
                            dec_pc          <= bus.pc;
                            exe_pc          <= dec_pc;
                        end
                        state        <= ST_FETCH;
                        bus.imem_req <= 1'b1;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a transaction-level model of outstanding
// fetches and the pipeline PCs, directed corner cases, then random traffic.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [15:0] NOP_W  = 16'h0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_ctrl_if bus();

    fetch_ctrl #(.RESET_PC(RST_PC), .NOP(NOP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int gnt_pct = 100;
    logic cmp_en = 1'b1;

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 16'h2005;
        return a[16:1] ^ 16'h1FC3;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic st, input logic bt, input logic [31:0] d);
        @(negedge clk);
        bus.stall             = st;
        bus.branch_taken      = bt;
        bus.delta_instruction = d;
    endtask

    // Memory: grants with a given probability, answers exactly one cycle after each grant.
    logic        pend = 1'b0;
    logic        stale = 1'b0;
    logic [31:0] pend_addr = '0;
    always @(negedge clk) begin
        bus.imem_rvalid = pend | stale;
        bus.imem_rdata  = pend ? mem_word(pend_addr) : 16'($urandom);
        pend  = 1'b0;
        stale = 1'b0;
        bus.imem_gnt = bus.imem_req && (int'($urandom_range(0, 99)) < gnt_pct);
        if (bus.imem_gnt) begin
            pend      = 1'b1;
            pend_addr = bus.imem_addr;
        end
    end

    // Reference model: outstanding fetch bookkeeping rather than FSM states.
    logic [31:0] m_fetch, m_pc, m_dec, m_exe, m_if_addr, m_buf_addr, m_t;
    logic [15:0] m_instr, m_buf_data;
    logic        m_req, m_if, m_if_drop, m_buf, m_granted, m_arrives;

    task automatic model_deliver(input logic [15:0] w, input logic [31:0] a);
        m_exe   = m_dec;
        m_dec   = m_pc;
        m_pc    = a;
        m_instr = w;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fetch = RST_PC;
            m_pc = RST_PC - 32'd2;
            m_dec = RST_PC - 32'd2;
            m_exe = RST_PC - 32'd2;
            m_instr = NOP_W;
            m_req = 1'b0;
            m_if = 1'b0;
            m_if_drop = 1'b0;
            m_buf = 1'b0;
        end else begin
            m_granted = m_req && bus.imem_gnt;
            m_arrives = m_if && bus.imem_rvalid;
            if (bus.branch_taken) begin
                m_t = m_exe + (bus.delta_instruction << 1);
                m_fetch = m_t;
                model_deliver(NOP_W, m_t - 32'd2);
                m_buf = 1'b0;
                if (m_granted || (m_if && !m_arrives)) begin
                    m_if = 1'b1;
                    m_if_drop = 1'b1;
                end else begin
                    m_if = 1'b0;
                end
                m_req = !m_if;
            end else if (m_arrives) begin
                m_if = 1'b0;
                if (m_if_drop) begin
                    m_req = !bus.stall;
                end else if (bus.stall) begin
                    m_buf = 1'b1;
                    m_buf_data = bus.imem_rdata;
                    m_buf_addr = m_if_addr;
                    m_req = 1'b0;
                end else begin
                    model_deliver(bus.imem_rdata, m_if_addr);
                    m_req = 1'b1;
                end
            end else if (m_granted) begin
                m_if = 1'b1;
                m_if_drop = 1'b0;
                m_if_addr = m_fetch;
                m_fetch = m_fetch + 32'd2;
                m_req = 1'b0;
            end else if (m_buf) begin
                if (!bus.stall) begin
                    model_deliver(m_buf_data, m_buf_addr);
                    m_buf = 1'b0;
                    m_req = 1'b1;
                end else begin
                    m_req = 1'b0;
                end
            end else if (m_if) begin
                m_req = 1'b0;
            end else begin
                m_req = !bus.stall;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check_output("req", 32'(bus.imem_req), 32'(m_req));
            if (m_req) check_output("addr", bus.imem_addr, m_fetch);
            check_output("instr", 32'(bus.instruction), 32'(m_instr));
            check_output("pc", bus.pc, m_pc);
        end
    end

    initial begin
        logic found;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.delta_instruction = '0;
        gnt_pct = 100;

        repeat (3) apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("rst_req", 32'(bus.imem_req), 32'h0);
        check_output("rst_instr", 32'(bus.instruction), 32'(NOP_W));
        check_output("rst_pc", bus.pc, 32'hFFFF_FFFE);
        rst_n = 1'b1;

        // First fetch after reset release, zero-wait memory
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("c1_req", 32'(bus.imem_req), 32'h1);
        check_output("c1_addr", bus.imem_addr, 32'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("c2_req", 32'(bus.imem_req), 32'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("c3_instr", 32'(bus.instruction), 32'h2005);
        check_output("c3_pc", bus.pc, 32'h0);
        check_output("c3_addr", bus.imem_addr, 32'h2);

        // Stall across the response of address 2
        apply_stimulus(1'b1, 1'b0, 32'h0);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        check_output("hold1_instr", 32'(bus.instruction), 32'h2005);
        check_output("hold1_req", 32'(bus.imem_req), 32'h0);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        check_output("hold2_instr", 32'(bus.instruction), 32'h2005);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("hold3_instr", 32'(bus.instruction), 32'h2005);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("unstall_instr", 32'(bus.instruction), 32'h1FC2);
        check_output("unstall_pc", bus.pc, 32'h2);
        check_output("unstall_addr", bus.imem_addr, 32'h4);

        // Branch in WAIT with exe_pc=0x10, delta=-4
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            apply_stimulus(1'b0, 1'b0, 32'h0);
            if (m_exe == 32'h10 && m_if && !m_if_drop) found = 1'b1;
        end
        check_output("wait_exe10", 32'(found), 32'h1);
        bus.branch_taken = 1'b1;
        bus.delta_instruction = 32'hFFFF_FFFC;
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("br_instr", 32'(bus.instruction), 32'(NOP_W));
        check_output("br_pc", bus.pc, 32'h6);
        check_output("br_addr", bus.imem_addr, 32'h8);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("br_tgt_instr", 32'(bus.instruction), 32'h1FC7);
        check_output("br_tgt_pc", bus.pc, 32'h8);

        // Asynchronous reset in the middle of a WAIT cycle, stale rvalid after release
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            apply_stimulus(1'b0, 1'b0, 32'h0);
            if (m_if && !m_if_drop) found = 1'b1;
        end
        check_output("wait_inflight", 32'(found), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_output("arst_req", 32'(bus.imem_req), 32'h0);
        check_output("arst_instr", 32'(bus.instruction), 32'(NOP_W));
        check_output("arst_pc", bus.pc, 32'hFFFF_FFFE);
        stale = 1'b1;
        @(negedge clk);
        #1 rst_n = 1'b1;
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("rel_req", 32'(bus.imem_req), 32'h1);
        check_output("rel_addr", bus.imem_addr, 32'h0);
        check_output("rel_instr", 32'(bus.instruction), 32'(NOP_W));
        apply_stimulus(1'b0, 1'b0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("rel_first", 32'(bus.instruction), 32'h2005);

        // Branch together with stall while HOLD has a word buffered
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            apply_stimulus(1'b0, 1'b0, 32'h0);
            if (m_exe == 32'h0 && m_if && !m_if_drop) found = 1'b1;
        end
        check_output("wait_exe0", 32'(found), 32'h1);
        bus.stall = 1'b1;
        gnt_pct = 0;
        apply_stimulus(1'b1, 1'b1, 32'h3);
        check_output("hb_req0", 32'(bus.imem_req), 32'h0);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        check_output("hb_instr", 32'(bus.instruction), 32'(NOP_W));
        check_output("hb_pc", bus.pc, 32'h4);
        check_output("hb_addr", bus.imem_addr, 32'h6);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("hb_stall_req", 32'(bus.imem_req), 32'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("hb_rel_req", 32'(bus.imem_req), 32'h1);
        check_output("hb_rel_addr", bus.imem_addr, 32'h6);
        check_output("hb_flushed", 32'(bus.instruction), 32'(NOP_W));
        gnt_pct = 100;

        // Redirect to the top of the address space and watch it wrap
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            apply_stimulus(1'b0, 1'b0, 32'h0);
            if (m_if && !m_if_drop) found = 1'b1;
        end
        check_output("wait_wrap", 32'(found), 32'h1);
        bus.branch_taken = 1'b1;
        bus.delta_instruction = (32'hFFFF_FFFE - m_exe) >> 1;
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("wrap_top", bus.imem_addr, 32'hFFFF_FFFE);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check_output("wrap_zero", bus.imem_addr, 32'h0);
        check_output("wrap_instr", 32'(bus.instruction), 32'hE03C);
        check_output("wrap_pc", bus.pc, 32'hFFFF_FFFE);

        // Random traffic: variable grant latency, stalls and branches
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) gnt_pct = int'($urandom_range(30, 100));
            apply_stimulus(($urandom % 4) == 0, ($urandom % 10) == 0,
                           32'($urandom_range(0, 64)) - 32'd32);
        end
        apply_stimulus(1'b0, 1'b0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
